// File: rtl/link_tx_scheduler_pkg.sv
// Shared types and constants for the board-to-board transmit link.
package link_tx_scheduler_pkg;

   localparam int unsigned FRAME_BITS = 18;
   localparam int unsigned PAYLOAD_W  = 12;
   localparam int unsigned NUM_REQ    = 4;

   // Pending-flag slots, ordered highest priority first
   localparam int unsigned IDX_CONNECT = 0;
   localparam int unsigned IDX_START   = 1;
   localparam int unsigned IDX_FINISH  = 2;
   localparam int unsigned IDX_CELL    = 3;

   typedef enum logic [2:0] {
      OP_NONE    = 3'd0,
      OP_CONNECT = 3'd1,
      OP_START   = 3'd2,
      OP_FINISH  = 3'd3,
      OP_CELL    = 3'd4
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_ACK,
      ST_GAP
   } state_e;

   typedef struct packed {
      logic [3:0] val;
      logic [3:0] col;
      logic [3:0] row;
   } cell_t;

   // Bit 0 goes on the wire first: start, opcode, payload, even parity, stop
   function automatic logic [FRAME_BITS-1:0] build_frame(input opcode_e op,
                                                         input logic [PAYLOAD_W-1:0] payload);
      logic parity;
      parity = ^{payload, op};
      return {1'b1, parity, payload, op, 1'b0};
   endfunction

endpackage

// File: rtl/link_frame_shifter.sv
// Serializes one framed word onto the link, holding each bit for BIT_CYCLES clocks.
module link_frame_shifter
   import link_tx_scheduler_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 5000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] frame,
   output logic                  tx_line,
   output logic                  done_c
);

   localparam int unsigned CYC_W = $clog2(BIT_CYCLES + 1);
   localparam int unsigned BIT_W = $clog2(FRAME_BITS);

   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [CYC_W-1:0]      cyc_q, cyc_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  active_q, active_d;
   logic                  tx_line_q, tx_line_d;

   // Load puts the start bit on the line at the same edge the FSM enters SEND
   always_comb begin
      shreg_d   = shreg_q;
      cyc_d     = cyc_q;
      bit_d     = bit_q;
      active_d  = active_q;
      tx_line_d = tx_line_q;
      done_c    = 1'b0;
      if (load) begin
         shreg_d   = frame;
         cyc_d     = '0;
         bit_d     = '0;
         active_d  = 1'b1;
         tx_line_d = frame[0];
      end else if (active_q) begin
         if (cyc_q == CYC_W'(BIT_CYCLES - 1)) begin
            cyc_d = '0;
            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
               active_d  = 1'b0;
               tx_line_d = 1'b1;
               done_c    = 1'b1;
            end else begin
               bit_d     = bit_q + BIT_W'(1);
               shreg_d   = shreg_q >> 1;
               tx_line_d = shreg_q[1];
            end
         end else begin
            cyc_d = cyc_q + CYC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q   <= '0;
         cyc_q     <= '0;
         bit_q     <= '0;
         active_q  <= 1'b0;
         tx_line_q <= 1'b1;
      end else begin
         shreg_q   <= shreg_d;
         cyc_q     <= cyc_d;
         bit_q     <= bit_d;
         active_q  <= active_d;
         tx_line_q <= tx_line_d;
      end
   end

   assign tx_line = tx_line_q;

endmodule

// File: rtl/link_tx_scheduler.sv
// Arbitrates link messages by fixed priority, sends them framed, and
// retries on missing acknowledge until the message is dropped.
module link_tx_scheduler
   import link_tx_scheduler_pkg::*;
#(
   parameter int unsigned BIT_CYCLES  = 5000,
   parameter int unsigned ACK_TIMEOUT = 200000,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       link_enable,
   input  logic       req_connect,
   input  logic       req_start,
   input  logic       req_finish,
   input  logic       req_cell,
   input  logic [3:0] cell_row,
   input  logic [3:0] cell_col,
   input  logic [3:0] cell_val,
   input  logic       rx_ack,
   input  logic [2:0] rx_ack_opcode,
   output logic       tx_line,
   output logic       cell_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_fail,
   output logic [2:0] tx_opcode,
   output logic       link_error
);

   localparam int unsigned TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

   state_e                state_q, state_d;
   opcode_e               opcode_q, opcode_d;
   logic [PAYLOAD_W-1:0]  payload_q, payload_d;
   logic [NUM_REQ-1:0]    pend_q, pend_d;
   cell_t                 cell_q, cell_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic                  retry_pend_q, retry_pend_d;
   logic                  cell_ready_q, cell_ready_d;
   logic                  busy_q, busy_d;
   logic                  tx_done_q, tx_done_d;
   logic                  tx_fail_q, tx_fail_d;
   logic                  link_error_q, link_error_d;

   logic [NUM_REQ-1:0]    req_set;
   logic [NUM_REQ-1:0]    grant;
   logic                  cell_accept;
   logic                  ack_hit;
   logic                  load_c;
   logic                  shift_done_c;
   logic [FRAME_BITS-1:0] frame;

   assign cell_accept = req_cell & cell_ready_q & link_enable;
   assign ack_hit     = rx_ack & (rx_ack_opcode == opcode_q);

   always_comb begin
      req_set              = '0;
      req_set[IDX_CONNECT] = req_connect & link_enable;
      req_set[IDX_START]   = req_start & link_enable;
      req_set[IDX_FINISH]  = req_finish & link_enable;
      req_set[IDX_CELL]    = cell_accept;
   end

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      payload_d    = payload_q;
      cell_d       = cell_q;
      tmr_d        = '0;
      retry_d      = retry_q;
      retry_pend_d = retry_pend_q;
      cell_ready_d = cell_ready_q;
      tx_done_d    = 1'b0;
      tx_fail_d    = 1'b0;
      link_error_d = link_error_q;
      grant        = '0;
      load_c       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (|pend_q) begin
               payload_d = '0;
               if (pend_q[IDX_CONNECT]) begin
                  grant[IDX_CONNECT] = 1'b1;
                  opcode_d           = OP_CONNECT;
               end else if (pend_q[IDX_START]) begin
                  grant[IDX_START] = 1'b1;
                  opcode_d         = OP_START;
               end else if (pend_q[IDX_FINISH]) begin
                  grant[IDX_FINISH] = 1'b1;
                  opcode_d          = OP_FINISH;
               end else begin
                  grant[IDX_CELL] = 1'b1;
                  opcode_d        = OP_CELL;
                  payload_d       = cell_q;
               end
               retry_d      = '0;
               retry_pend_d = 1'b0;
               load_c       = 1'b1;
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            if (shift_done_c) begin
               state_d = ST_WAIT_ACK;
            end
         end
         // A matching ack in the expiry cycle still counts as delivered
         ST_WAIT_ACK: begin
            if (ack_hit) begin
               tx_done_d    = 1'b1;
               retry_pend_d = 1'b0;
               if (opcode_q == OP_CELL) cell_ready_d = 1'b1;
               state_d      = ST_GAP;
            end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d      = retry_q + RETRY_W'(1);
                  retry_pend_d = 1'b1;
               end else begin
                  tx_fail_d    = 1'b1;
                  link_error_d = 1'b1;
                  retry_pend_d = 1'b0;
                  if (opcode_q == OP_CELL) cell_ready_d = 1'b1;
               end
               state_d = ST_GAP;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
               if (retry_pend_q) begin
                  retry_pend_d = 1'b0;
                  load_c       = 1'b1;
                  state_d      = ST_SEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A request arriving with its own grant keeps the flag set
      pend_d = (pend_q & ~grant) | req_set;
      if (cell_accept) begin
         cell_d       = '{val: cell_val, col: cell_col, row: cell_row};
         cell_ready_d = 1'b0;
      end
      busy_d = (state_d != ST_IDLE);
   end

   assign frame = build_frame(opcode_d, payload_d);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         opcode_q     <= OP_NONE;
         payload_q    <= '0;
         pend_q       <= '0;
         cell_q       <= '0;
         tmr_q        <= '0;
         retry_q      <= '0;
         retry_pend_q <= 1'b0;
         cell_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         tx_done_q    <= 1'b0;
         tx_fail_q    <= 1'b0;
         link_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         payload_q    <= payload_d;
         pend_q       <= pend_d;
         cell_q       <= cell_d;
         tmr_q        <= tmr_d;
         retry_q      <= retry_d;
         retry_pend_q <= retry_pend_d;
         cell_ready_q <= cell_ready_d;
         busy_q       <= busy_d;
         tx_done_q    <= tx_done_d;
         tx_fail_q    <= tx_fail_d;
         link_error_q <= link_error_d;
      end
   end

   link_frame_shifter #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_shifter (
      .clk    (clk),
      .reset  (reset),
      .load   (load_c),
      .frame  (frame),
      .tx_line(tx_line),
      .done_c (shift_done_c)
   );

   assign cell_ready = cell_ready_q;
   assign busy       = busy_q;
   assign tx_done    = tx_done_q;
   assign tx_fail    = tx_fail_q;
   assign tx_opcode  = opcode_q;
   assign link_error = link_error_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed bench for link_tx_scheduler: frame contents, arbitration, ack, retry and reset.
module tb_link_tx_scheduler;

   localparam int unsigned BIT_CYCLES  = 4;
   localparam int unsigned ACK_TIMEOUT = 20;
   localparam int unsigned GAP_CYCLES  = 2;
   localparam int unsigned MAX_RETRY   = 3;

   logic       clk;
   logic       reset;
   logic       link_enable;
   logic       req_connect;
   logic       req_start;
   logic       req_finish;
   logic       req_cell;
   logic [3:0] cell_row;
   logic [3:0] cell_col;
   logic [3:0] cell_val;
   logic       rx_ack;
   logic [2:0] rx_ack_opcode;
   logic       tx_line;
   logic       cell_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_fail;
   logic [2:0] tx_opcode;
   logic       link_error;

   int tests = 0;
   int fails = 0;

   link_tx_scheduler #(
      .BIT_CYCLES (BIT_CYCLES),
      .ACK_TIMEOUT(ACK_TIMEOUT),
      .GAP_CYCLES (GAP_CYCLES),
      .MAX_RETRY  (MAX_RETRY)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .link_enable  (link_enable),
      .req_connect  (req_connect),
      .req_start    (req_start),
      .req_finish   (req_finish),
      .req_cell     (req_cell),
      .cell_row     (cell_row),
      .cell_col     (cell_col),
      .cell_val     (cell_val),
      .rx_ack       (rx_ack),
      .rx_ack_opcode(rx_ack_opcode),
      .tx_line      (tx_line),
      .cell_ready   (cell_ready),
      .busy         (busy),
      .tx_done      (tx_done),
      .tx_fail      (tx_fail),
      .tx_opcode    (tx_opcode),
      .link_error   (link_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          sel;
      logic [3:0]  row;
      logic [3:0]  col;
      logic [3:0]  val;
      int          ack_dly;
      logic [17:0] exp_frame;
      logic [2:0]  exp_op;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // sel bits: 0 connect, 1 start, 2 finish, 3 cell
   task automatic pulse_req(input int sel, input logic [3:0] row, input logic [3:0] col,
                            input logic [3:0] val);
      req_connect = sel[0];
      req_start   = sel[1];
      req_finish  = sel[2];
      req_cell    = sel[3];
      cell_row    = row;
      cell_col    = col;
      cell_val    = val;
      step();
      req_connect = 1'b0;
      req_start   = 1'b0;
      req_finish  = 1'b0;
      req_cell    = 1'b0;
   endtask

   task automatic wait_start(input int max, output int n);
      n = 0;
      while (tx_line !== 1'b0 && n < max) begin
         step();
         n++;
      end
   endtask

   // Starts on the first start-bit cycle, ends on the last stop-bit cycle
   task automatic capture(output logic [17:0] f, output int shape_bad);
      shape_bad = 0;
      f = '0;
      for (int b = 0; b < 18; b++) begin
         for (int c = 0; c < int'(BIT_CYCLES); c++) begin
            if (c == 0) f[b] = tx_line;
            else if (tx_line !== f[b]) shape_bad++;
            if (!(b == 17 && c == int'(BIT_CYCLES) - 1)) step();
         end
      end
   endtask

   task automatic send_ack(input int dly, input logic [2:0] op);
      repeat (dly) step();
      rx_ack        = 1'b1;
      rx_ack_opcode = op;
      step();
      rx_ack        = 1'b0;
      rx_ack_opcode = 3'd0;
   endtask

   task automatic quiet(input int n, input string name);
      int bad;
      bad = 0;
      repeat (n) begin
         step();
         if (tx_line !== 1'b1 || tx_done !== 1'b0 || tx_fail !== 1'b0) bad++;
      end
      chk(name, 32'(bad), 32'd0);
   endtask

   initial begin
      logic [17:0] f;
      logic [17:0] exp2 [3];
      logic [2:0]  op2  [3];
      int          n;
      int          bad;

      vecs[0] = '{sel: 2, row: 4'd0, col: 4'd0, val: 4'd0, ack_dly: 3,  exp_frame: 18'h30004, exp_op: 3'd2};
      vecs[1] = '{sel: 1, row: 4'd0, col: 4'd0, val: 4'd0, ack_dly: 1,  exp_frame: 18'h30002, exp_op: 3'd1};
      vecs[2] = '{sel: 4, row: 4'd0, col: 4'd0, val: 4'd0, ack_dly: 20, exp_frame: 18'h20006, exp_op: 3'd3};
      vecs[3] = '{sel: 8, row: 4'd8, col: 4'd2, val: 4'd5, ack_dly: 5,  exp_frame: 18'h35288, exp_op: 3'd4};
      vecs[4] = '{sel: 8, row: 4'd0, col: 4'd8, val: 4'd9, ack_dly: 10, exp_frame: 18'h29808, exp_op: 3'd4};
      vecs[5] = '{sel: 8, row: 4'd3, col: 4'd7, val: 4'd0, ack_dly: 19, exp_frame: 18'h20738, exp_op: 3'd4};

      reset = 1'b1; link_enable = 1'b1;
      req_connect = 1'b0; req_start = 1'b0; req_finish = 1'b0; req_cell = 1'b0;
      cell_row = 4'd0; cell_col = 4'd0; cell_val = 4'd0;
      rx_ack = 1'b0; rx_ack_opcode = 3'd0;
      repeat (3) step();
      chk("rst_tx_line", 32'(tx_line), 32'd1);
      chk("rst_cell_ready", 32'(cell_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_tx_fail", 32'(tx_fail), 32'd0);
      chk("rst_tx_opcode", 32'(tx_opcode), 32'd0);
      chk("rst_link_error", 32'(link_error), 32'd0);
      reset = 1'b0;
      step();

      // Single-message vectors
      for (int i = 0; i < 6; i++) begin
         pulse_req(vecs[i].sel, vecs[i].row, vecs[i].col, vecs[i].val);
         chk($sformatf("v%0d_cell_ready_req", i), 32'(cell_ready), (vecs[i].exp_op == 3'd4) ? 32'd0 : 32'd1);
         wait_start(10, n);
         chk($sformatf("v%0d_start_latency", i), 32'(n), 32'd1);
         capture(f, bad);
         chk($sformatf("v%0d_frame_shape", i), 32'(bad), 32'd0);
         chk($sformatf("v%0d_frame_bits", i), 32'(f), 32'(vecs[i].exp_frame));
         send_ack(vecs[i].ack_dly, vecs[i].exp_op);
         chk($sformatf("v%0d_tx_done", i), 32'(tx_done), 32'd1);
         chk($sformatf("v%0d_tx_opcode", i), 32'(tx_opcode), 32'(vecs[i].exp_op));
         chk($sformatf("v%0d_cell_ready_done", i), 32'(cell_ready), 32'd1);
         step();
         chk($sformatf("v%0d_done_one_cycle", i), 32'(tx_done), 32'd0);
         step();
         chk($sformatf("v%0d_busy_idle", i), 32'(busy), 32'd0);
      end

      // Requests while link disabled are not latched
      link_enable = 1'b0;
      pulse_req(2, 4'd0, 4'd0, 4'd0);
      link_enable = 1'b1;
      quiet(30, "disabled_req_ignored");

      // Simultaneous requests go out by priority
      exp2[0] = 18'h30002; op2[0] = 3'd1;
      exp2[1] = 18'h30004; op2[1] = 3'd2;
      exp2[2] = 18'h35288; op2[2] = 3'd4;
      pulse_req(11, 4'd8, 4'd2, 4'd5);
      for (int k = 0; k < 3; k++) begin
         wait_start(20, n);
         capture(f, bad);
         chk($sformatf("prio%0d_frame_bits", k), 32'(f), 32'(exp2[k]));
         send_ack(2, op2[k]);
         chk($sformatf("prio%0d_tx_done", k), 32'(tx_done), 32'd1);
         chk($sformatf("prio%0d_tx_opcode", k), 32'(tx_opcode), 32'(op2[k]));
         chk($sformatf("prio%0d_cell_ready", k), 32'(cell_ready), (k == 2) ? 32'd1 : 32'd0);
      end
      repeat (2) step();

      // Wrong-opcode ack ignored, later correct ack completes the CELL frame
      pulse_req(8, 4'd4, 4'd6, 4'd7);
      wait_start(10, n);
      capture(f, bad);
      chk("wrongack_frame_bits", 32'(f), 32'h37648);
      send_ack(3, 3'd2);
      chk("wrongack_ignored", 32'(tx_done), 32'd0);
      send_ack(11, 3'd4);
      chk("wrongack_then_done", 32'(tx_done), 32'd1);
      quiet(100, "wrongack_no_retx");

      // Second cell request while holding register is full is dropped
      pulse_req(8, 4'd1, 4'd1, 4'd1);
      pulse_req(8, 4'd2, 4'd2, 4'd2);
      wait_start(10, n);
      capture(f, bad);
      chk("cellbusy_frame_bits", 32'(f), 32'h21118);
      send_ack(2, 3'd4);
      chk("cellbusy_tx_done", 32'(tx_done), 32'd1);
      chk("cellbusy_cell_ready", 32'(cell_ready), 32'd1);
      quiet(120, "cellbusy_no_second_frame");

      // No ack ever: 4 frames, then drop
      pulse_req(4, 4'd0, 4'd0, 4'd0);
      for (int r = 0; r < 4; r++) begin
         wait_start(40, n);
         if (r == 0) chk("retry_first_latency", 32'(n), 32'd1);
         else chk($sformatf("retry%0d_spacing", r), 32'(n), 32'd23);
         capture(f, bad);
         chk($sformatf("retry%0d_frame_bits", r), 32'(f), 32'h20006);
      end
      n = 0;
      while (tx_fail !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("fail_latency", 32'(n), 32'd21);
      chk("fail_tx_opcode", 32'(tx_opcode), 32'd3);
      chk("fail_link_error", 32'(link_error), 32'd1);
      step();
      chk("fail_one_cycle", 32'(tx_fail), 32'd0);
      step();
      chk("fail_busy_idle", 32'(busy), 32'd0);
      quiet(100, "fail_no_fifth_frame");
      chk("link_error_sticky", 32'(link_error), 32'd1);

      // Reset in the 10th bit of a frame with a cell still pending
      pulse_req(9, 4'd0, 4'd0, 4'd1);
      wait_start(10, n);
      repeat (36) step();
      chk("midrst_bit9_low", 32'(tx_line), 32'd0);
      chk("midrst_cell_ready_before", 32'(cell_ready), 32'd0);
      reset = 1'b1;
      step();
      chk("midrst_tx_line", 32'(tx_line), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cell_ready", 32'(cell_ready), 32'd1);
      chk("midrst_tx_done", 32'(tx_done), 32'd0);
      chk("midrst_tx_fail", 32'(tx_fail), 32'd0);
      chk("midrst_link_error", 32'(link_error), 32'd0);
      reset = 1'b0;
      quiet(150, "midrst_no_frame_after");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
